alu_exec_unit: RTL and testbench

- Execute-stage ALU that consumes the 4-bit ALU control code and the two register operands, and produces a registered result plus condition flags.
- Sits directly downstream of the ALU control decoder; its result and flags feed the writeback mux and the branch-decision logic.
- Logic and arithmetic operations complete in one cycle.
- Shifts are iterative (one bit position per cycle) to save area; a start/busy/done handshake lets the datapath controller stall.

---
 rtl/alu_exec_unit.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
//   Execute-stage ALU. Logic and arithmetic operations complete in one cycle.
//   Shifts move one bit position per cycle behind a start/busy/done handshake.
//   Result and flags are registered and change only when done is issued.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous, active-high reset
//   start          operation request, sampled only while idle
//   AluControlLine 4-bit operation code from the ALU control decoder
//   a, b           operands; b[SHW-1:0] is the shift amount for shifts
//   busy           high while a shift is in flight
//   done           one-cycle pulse: result and flags are valid
//   result         registered result, held until the next completion
//   zero           result == 0
//   carry          carry-out / no-borrow / last bit shifted out
//   sign           result MSB
//   overflow       signed overflow for ADD/SUB (only with ALU_OVF_EN)
//
// Build option:
//   ALU_OVF_EN     when defined, adds the overflow output and its logic.
// -----------------------------------------------------------------------------
module alu_exec_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       AluControlLine,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             sign
`ifdef ALU_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_NOR = 4'b0101;
    localparam logic [3:0] OP_SLL = 4'b0110;
    localparam logic [3:0] OP_SRL = 4'b0111;
    localparam logic [3:0] OP_SRA = 4'b1000;

    // Compact shift-kind code kept for the duration of a shift, so the
    // opcode input is free to change once the operation is accepted.
    localparam logic [1:0] SK_SLL = 2'd0;
    localparam logic [1:0] SK_SRL = 2'd1;
    localparam logic [1:0] SK_SRA = 2'd2;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_nxt;
    logic [SHW-1:0]   cnt;
    logic [SHW-1:0]   cnt_nxt;
    logic [1:0]       kind;
    logic [1:0]       kind_nxt;
    logic             done_nxt;
    logic [WIDTH-1:0] result_nxt;
    logic             carry_nxt;
    logic [SHW-1:0]   k_in;
    logic             is_shift;
    logic [WIDTH:0]   onecyc;
    logic [WIDTH:0]   step;
`ifdef ALU_OVF_EN
    logic             ovf_nxt;
`endif

    // Single-cycle operations; returns {carry, result}.
    function automatic logic [WIDTH:0] alu_onecycle(
        input logic [3:0]       op,
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y
    );
        logic [WIDTH:0] ext;
        logic [WIDTH:0] ret;
        ext = {1'b0, x} - {1'b0, y};
        case (op)
            OP_ADD:  ret = {1'b0, x} + {1'b0, y};
            // MSB of the extended difference is the borrow; carry is its inverse.
            OP_SUB:  ret = {~ext[WIDTH], ext[WIDTH-1:0]};
            OP_AND:  ret = {1'b0, x & y};
            OP_OR:   ret = {1'b0, x | y};
            OP_XOR:  ret = {1'b0, x ^ y};
            OP_NOR:  ret = {1'b0, ~(x | y)};
            default: ret = {1'b0, x};
        endcase
        return ret;
    endfunction

`ifdef ALU_OVF_EN
    // Signed overflow for ADD/SUB judged from operand and result signs.
    function automatic logic ovf_calc(
        input logic [3:0]       op,
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y
    );
        logic [WIDTH-1:0] s;
        logic             v;
        case (op)
            OP_ADD: begin
                s = x + y;
                v = (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
            end
            OP_SUB: begin
                s = x - y;
                v = (x[WIDTH-1] != y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
            end
            default: begin
                s = {WIDTH{1'b0}};
                v = 1'b0;
            end
        endcase
        return v;
    endfunction
`endif

    // One shift step; returns {bit shifted out, new value}.
    function automatic logic [WIDTH:0] shift_step(
        input logic [1:0]       k,
        input logic [WIDTH-1:0] v
    );
        logic [WIDTH:0] ret;
        case (k)
            SK_SLL:  ret = {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
            SK_SRL:  ret = {v[0], 1'b0, v[WIDTH-1:1]};
            SK_SRA:  ret = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
            default: ret = {1'b0, v};
        endcase
        return ret;
    endfunction

    assign k_in     = b[SHW-1:0];
    assign is_shift = (AluControlLine == OP_SLL) || (AluControlLine == OP_SRL) ||
                      (AluControlLine == OP_SRA);
    assign onecyc   = alu_onecycle(AluControlLine, a, b);
    assign step     = shift_step(kind, shreg);
    assign busy     = (state == ST_SHIFT);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: only a nonzero shift leaves IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start && is_shift && (k_in != {SHW{1'b0}})) begin
                    state_nxt = ST_SHIFT;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt == SHW'(1)) begin
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_SHIFT;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output/datapath next values; everything holds unless an operation completes.
    always_comb begin
        done_nxt   = 1'b0;
        result_nxt = result;
        carry_nxt  = carry;
        shreg_nxt  = shreg;
        cnt_nxt    = cnt;
        kind_nxt   = kind;
`ifdef ALU_OVF_EN
        ovf_nxt    = overflow;
`endif
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (is_shift) begin
                        if (k_in == {SHW{1'b0}}) begin
                            done_nxt   = 1'b1;
                            result_nxt = a;
                            carry_nxt  = 1'b0;
`ifdef ALU_OVF_EN
                            ovf_nxt    = 1'b0;
`endif
                        end else begin
                            shreg_nxt = a;
                            cnt_nxt   = k_in;
                            case (AluControlLine)
                                OP_SLL:  kind_nxt = SK_SLL;
                                OP_SRL:  kind_nxt = SK_SRL;
                                default: kind_nxt = SK_SRA;
                            endcase
                        end
                    end else begin
                        done_nxt   = 1'b1;
                        result_nxt = onecyc[WIDTH-1:0];
                        carry_nxt  = onecyc[WIDTH];
`ifdef ALU_OVF_EN
                        ovf_nxt    = ovf_calc(AluControlLine, a, b);
`endif
                    end
                end else begin
                    done_nxt = 1'b0;
                end
            end
            ST_SHIFT: begin
                shreg_nxt = step[WIDTH-1:0];
                cnt_nxt   = cnt - SHW'(1);
                // Last step: publish the shifted value and the bit that fell out.
                if (cnt == SHW'(1)) begin
                    done_nxt   = 1'b1;
                    result_nxt = step[WIDTH-1:0];
                    carry_nxt  = step[WIDTH];
`ifdef ALU_OVF_EN
                    ovf_nxt    = 1'b0;
`endif
                end else begin
                    done_nxt = 1'b0;
                end
            end
            default: done_nxt = 1'b0;
        endcase
    end

    // Datapath and output registers; zero/sign follow the new result only on done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done     <= 1'b0;
            result   <= {WIDTH{1'b0}};
            zero     <= 1'b0;
            carry    <= 1'b0;
            sign     <= 1'b0;
            shreg    <= {WIDTH{1'b0}};
            cnt      <= {SHW{1'b0}};
            kind     <= SK_SLL;
`ifdef ALU_OVF_EN
            overflow <= 1'b0;
`endif
        end else begin
            done   <= done_nxt;
            result <= result_nxt;
            carry  <= carry_nxt;
            shreg  <= shreg_nxt;
            cnt    <= cnt_nxt;
            kind   <= kind_nxt;
`ifdef ALU_OVF_EN
            overflow <= ovf_nxt;
`endif
            if (done_nxt) begin
                zero <= (result_nxt == {WIDTH{1'b0}});
                sign <= result_nxt[WIDTH-1];
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  alu_ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        zero;
    logic        carry;
    logic        sign;
`ifdef ALU_OVF_EN
    logic        overflow;
`endif

    int tests_run;
    int tests_failed;

    alu_exec_unit #(.WIDTH(32), .SHW(5)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .AluControlLine(alu_ctl),
        .a(a),
        .b(b),
        .busy(busy),
        .done(done),
        .result(result),
        .zero(zero),
        .carry(carry),
        .sign(sign)
`ifdef ALU_OVF_EN
        ,
        .overflow(overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: result, carry, overflow and latency from plain arithmetic.
    task automatic model(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                         output logic [31:0] r, output logic c, output logic o, output int lat);
        int     k;
        longint sa;
        longint sb;
        longint sr;
        longint ua;
        longint ub;
        k  = int'(bv[4:0]);
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        ua = longint'(av);
        ub = longint'(bv);
        c = 1'b0; o = 1'b0; lat = 0; sr = 64'sd0;
        case (op)
            4'd0: begin
                r  = av + bv;
                c  = (ua + ub) >= 64'sd4294967296;
                sr = sa + sb;
                o  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'd1: begin
                r  = av - bv;
                c  = (ua >= ub);
                sr = sa - sb;
                o  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'd2: r = av & bv;
            4'd3: r = av | bv;
            4'd4: r = av ^ bv;
            4'd5: r = ~(av | bv);
            4'd6: begin
                r = av << k; lat = k;
                if (k > 0) c = av[32-k];
            end
            4'd7: begin
                r = av >> k; lat = k;
                if (k > 0) c = av[k-1];
            end
            4'd8: begin
                r = $unsigned($signed(av) >>> k); lat = k;
                if (k > 0) c = av[k-1];
            end
            default: r = av;
        endcase
    endtask

    // Issue one operation, scramble inputs after acceptance, wait for done.
    task automatic issue_op(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                            output logic [31:0] r, output logic z, output logic c,
                            output logic s, output logic o, output int lat, output bit prot_ok);
        prot_ok = 1'b1;
        @(negedge clk);
        start = 1'b1; alu_ctl = op; a = av; b = bv;
        @(negedge clk);
        start = 1'b0; alu_ctl = 4'($urandom); a = $urandom; b = $urandom;
        lat = 0;
        while (!done && lat < 64) begin
            if (!busy) prot_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (!done) lat = -1;
        else if (busy) prot_ok = 1'b0;
        r = result; z = zero; c = carry; s = sign;
`ifdef ALU_OVF_EN
        o = overflow;
`else
        o = 1'b0;
`endif
    endtask

    task automatic test_reset();
        logic [31:0] r; logic z, c, s, o; int lat; bit ok;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({busy, done, zero, carry, sign, result} !== 37'd0) begin
            tests_failed++;
            $display("FAIL reset_values: got busy=%b done=%b z=%b c=%b s=%b res=%h, want all 0",
                     busy, done, zero, carry, sign, result);
        end
        rst = 1'b0;
        issue_op(4'd0, 32'd10, 32'd20, r, z, c, s, o, lat, ok);
        // SLL a=1 k=20, then reset in the middle of it.
        @(negedge clk);
        start = 1'b1; alu_ctl = 4'd6; a = 32'd1; b = 32'd20;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_busy_before: got %b want 1", busy);
        end
        @(posedge clk); #2 rst = 1'b1; #1;
        tests_run++;
        if ({busy, done, zero, carry, sign, result} !== 37'd0) begin
            tests_failed++;
            $display("FAIL reset_midshift: got busy=%b done=%b z=%b c=%b s=%b res=%h, want all 0",
                     busy, done, zero, carry, sign, result);
        end
        @(negedge clk); rst = 1'b0;
        issue_op(4'd0, 32'd3, 32'd4, r, z, c, s, o, lat, ok);
        tests_run++;
        if (r !== 32'd7 || lat !== 0 || !ok) begin
            tests_failed++;
            $display("FAIL reset_after_add: got res=%h lat=%0d ok=%b want res=7 lat=0 ok=1", r, lat, ok);
        end
    endtask

    task automatic test_arith();
        logic [31:0] r; logic z, c, s, o; int lat; bit ok;
        issue_op(4'd0, 32'hFFFFFFFF, 32'd1, r, z, c, s, o, lat, ok);
        tests_run++;
        if (r !== 32'd0 || z !== 1'b1 || c !== 1'b1 || s !== 1'b0 || lat !== 0) begin
            tests_failed++;
            $display("FAIL add_wrap: got res=%h z=%b c=%b s=%b lat=%0d want 0 1 1 0 lat=0", r, z, c, s, lat);
        end
        issue_op(4'd1, 32'd5, 32'd7, r, z, c, s, o, lat, ok);
        tests_run++;
        if (r !== 32'hFFFFFFFE || z !== 1'b0 || c !== 1'b0 || s !== 1'b1 || lat !== 0) begin
            tests_failed++;
            $display("FAIL sub_borrow: got res=%h z=%b c=%b s=%b lat=%0d want fffffffe 0 0 1 lat=0", r, z, c, s, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  ops [4];
        logic [31:0] exp [4];
        ops = '{4'd2, 4'd3, 4'd4, 4'd5};
        exp = '{32'h00F000F0, 32'hFFF0FFF0, 32'hFF00FF00, 32'h000F000F};
        @(negedge clk);
        start = 1'b1; a = 32'hF0F0F0F0; b = 32'h0FF00FF0; alu_ctl = ops[0];
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            tests_run++;
            if (done !== 1'b1 || result !== exp[i-1]) begin
                tests_failed++;
                $display("FAIL b2b_op%0d: got done=%b res=%h want done=1 res=%h", i-1, done, result, exp[i-1]);
            end
            if (i < 4) alu_ctl = ops[i];
            else start = 1'b0;
        end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_done_drop: got done=%b want 0", done);
        end
    endtask

    task automatic test_shifts();
        logic [31:0] r; logic z, c, s, o; int lat; bit ok;
        issue_op(4'd8, 32'h80000000, 32'd4, r, z, c, s, o, lat, ok);
        tests_run++;
        if (r !== 32'hF8000000 || c !== 1'b0 || s !== 1'b1 || lat !== 4 || !ok) begin
            tests_failed++;
            $display("FAIL sra4: got res=%h c=%b s=%b lat=%0d ok=%b want f8000000 0 1 lat=4 ok=1", r, c, s, lat, ok);
        end
        issue_op(4'd6, 32'h80000001, 32'd1, r, z, c, s, o, lat, ok);
        tests_run++;
        if (r !== 32'h00000002 || c !== 1'b1 || lat !== 1 || !ok) begin
            tests_failed++;
            $display("FAIL sll1: got res=%h c=%b lat=%0d ok=%b want 00000002 1 lat=1 ok=1", r, c, lat, ok);
        end
        issue_op(4'd7, 32'h12345678, 32'hFFFFFFE0, r, z, c, s, o, lat, ok);
        tests_run++;
        if (r !== 32'h12345678 || c !== 1'b0 || lat !== 0) begin
            tests_failed++;
            $display("FAIL shift_k0: got res=%h c=%b lat=%0d want 12345678 0 lat=0", r, c, lat);
        end
    endtask

    task automatic test_ignored_start();
        logic [31:0] er; logic ec, eo; int elat;
        int n_done; int at; logic [31:0] rr; logic rc;
        model(4'd7, 32'hDEADBEEF, 32'd31, er, ec, eo, elat);
        n_done = 0; at = -1; rr = 32'd0; rc = 1'b0;
        @(negedge clk);
        start = 1'b1; alu_ctl = 4'd7; a = 32'hDEADBEEF; b = 32'd31;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done) begin
                n_done++; at = i; rr = result; rc = carry;
            end
            if (i == 5) begin
                start = 1'b1; alu_ctl = 4'd0; a = 32'd1; b = 32'd1;
            end else begin
                start = 1'b0;
            end
        end
        tests_run++;
        if (n_done !== 1 || at !== elat || rr !== er || rc !== ec) begin
            tests_failed++;
            $display("FAIL ignored_start: got dones=%0d at=%0d res=%h c=%b want 1 at=%0d res=%h c=%b",
                     n_done, at, rr, rc, elat, er, ec);
        end
    endtask

    task automatic test_random();
        logic [31:0] av, bv, r, er; logic [3:0] op; logic z, c, s, o, ec, eo; int lat, elat; bit ok;
        for (int i = 0; i < 80; i++) begin
            op = 4'($urandom_range(0, 15));
            av = $urandom; bv = $urandom;
            if (i % 8 == 0) bv = bv & 32'hFFFFFFE0;
            model(op, av, bv, er, ec, eo, elat);
            issue_op(op, av, bv, r, z, c, s, o, lat, ok);
            tests_run++;
            if (r !== er || c !== ec || z !== (er == 32'd0) || s !== er[31] || lat !== elat || !ok) begin
                tests_failed++;
                $display("FAIL random_%0d op=%0d a=%h b=%h: got res=%h c=%b z=%b s=%b lat=%0d ok=%b want res=%h c=%b lat=%0d",
                         i, op, av, bv, r, c, z, s, lat, ok, er, ec, elat);
            end
`ifdef ALU_OVF_EN
            tests_run++;
            if (o !== eo) begin
                tests_failed++;
                $display("FAIL random_ovf_%0d op=%0d: got %b want %b", i, op, o, eo);
            end
`endif
        end
    endtask

`ifdef ALU_OVF_EN
    task automatic test_overflow();
        logic [31:0] r; logic z, c, s, o; int lat; bit ok;
        issue_op(4'd0, 32'h7FFFFFFF, 32'd1, r, z, c, s, o, lat, ok);
        tests_run++;
        if (o !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_add: got %b want 1", o);
        end
        issue_op(4'd1, 32'h80000000, 32'd1, r, z, c, s, o, lat, ok);
        tests_run++;
        if (o !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_sub: got %b want 1", o);
        end
        issue_op(4'd4, 32'h7FFFFFFF, 32'hFFFFFFFF, r, z, c, s, o, lat, ok);
        tests_run++;
        if (o !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_xor: got %b want 0", o);
        end
    endtask
`endif

    initial begin
        tests_run = 0; tests_failed = 0;
        rst = 1'b1; start = 1'b0; alu_ctl = 4'd0; a = 32'd0; b = 32'd0;
        test_reset();
        test_arith();
        test_back_to_back();
        test_shifts();
        test_ignored_start();
`ifdef ALU_OVF_EN
        test_overflow();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
